// File: rtl/cpu_trace_buffer.sv
// Per-cycle retire-stage trace capture into a circular FIFO with a first-word-fall-through readout.
// Optional macro TRACE_REGDIFF_EN: log register writes only when the value differs from a shadow copy.
module cpu_trace_buffer #(
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int MADDR_W     = 12,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 154,
  parameter int WRAP        = 0,
  parameter int CAPTURE_ALL = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [PC_W-1:0]          instr_i,
  input  logic                     rf_we_i,
  input  logic [4:0]               rf_waddr_i,
  input  logic [DATA_W-1:0]        rf_wdata_i,
  input  logic                     mem_we_i,
  input  logic [MADDR_W-1:0]       mem_addr_i,
  input  logic [DATA_W-1:0]        mem_wdata_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [CNT_W-1:0]         rd_cycle_o,
  output logic [PC_W-1:0]          rd_pc_o,
  output logic [PC_W-1:0]          rd_instr_o,
  output logic [1:0]               rd_flags_o,
  output logic [4:0]               rd_raddr_o,
  output logic [DATA_W-1:0]        rd_rdata_o,
  output logic [MADDR_W-1:0]       rd_maddr_o,
  output logic [DATA_W-1:0]        rd_mdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [1:0]               state_o,
  output logic                     overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef struct packed {
    logic [CNT_W-1:0]   cycle;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    instr;
    logic [1:0]         flags;
    logic [4:0]         raddr;
    logic [DATA_W-1:0]  rdata;
    logic [MADDR_W-1:0] maddr;
    logic [DATA_W-1:0]  mdata;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cycle;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  entry_t           r_head;
  entry_t           r_mem [DEPTH];

  logic             w_start_ok;
  logic             w_last;
  logic             w_sample;
  logic             w_rf_diff;
  logic             w_rf_q;
  logic             w_mem_q;
  logic             w_push_req;
  logic             w_full;
  logic             w_pop;
  logic             w_do_write;
  logic             w_overwrite;
  logic             w_drop;
  logic [CW-1:0]    w_count_next;
  logic [PTR_W-1:0] w_rptr_next;
  logic [PTR_W-1:0] w_wptr_next;
  entry_t           w_new;
  entry_t           w_head_next;

  // A new run may only be launched from IDLE or DONE
  assign w_start_ok = start_i && (r_state != S_RUN);
  assign w_sample   = (r_state == S_RUN) && !stop_i;
  assign w_last     = (MAX_CYCLES != 0) && (r_cycle == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_state_next = S_RUN;
      S_RUN: begin
        if (stop_i)      w_state_next = S_DONE;
        else if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef TRACE_REGDIFF_EN
  logic [DATA_W-1:0] r_shadow [32];

  assign w_rf_diff = (rf_wdata_i != r_shadow[rf_waddr_i]);

  // Shadow tracks every nonzero-index write, qualifying or not
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_ok) begin
      for (int k = 0; k < 32; k++) r_shadow[k] <= '0;
    end else if (rf_we_i && (rf_waddr_i != 5'd0)) begin
      r_shadow[rf_waddr_i] <= rf_wdata_i;
    end
  end
`else
  assign w_rf_diff = 1'b1;
`endif

  assign w_rf_q     = rf_we_i && (rf_waddr_i != 5'd0) && w_rf_diff;
  assign w_mem_q    = mem_we_i;
  assign w_push_req = w_sample && ((CAPTURE_ALL != 0) || w_rf_q || w_mem_q);

  always_comb begin
    w_new       = '0;
    w_new.cycle = r_cycle;
    w_new.pc    = pc_i;
    w_new.instr = instr_i;
    w_new.flags = {w_mem_q, w_rf_q};
    if (w_rf_q) begin
      w_new.raddr = rf_waddr_i;
      w_new.rdata = rf_wdata_i;
    end
    if (w_mem_q) begin
      w_new.maddr = mem_addr_i;
      w_new.mdata = mem_wdata_i;
    end
  end

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = (r_count != '0) && rd_ready_i;
  assign w_do_write  = w_push_req && (!w_full || w_pop || (WRAP != 0));
  assign w_overwrite = w_push_req && w_full && !w_pop && (WRAP != 0);
  assign w_drop      = w_push_req && w_full && !w_pop && (WRAP == 0);
  assign w_rptr_next = r_rptr + PTR_W'(w_pop || w_overwrite);
  assign w_wptr_next = r_wptr + PTR_W'(w_do_write);

  always_comb begin
    w_count_next = r_count;
    if (w_do_write && !w_pop && !w_overwrite) w_count_next = r_count + CW'(1);
    else if (!w_do_write && w_pop)            w_count_next = r_count - CW'(1);
  end

  // Next head: bypass the incoming entry when it lands in the head slot
  always_comb begin
    w_head_next = '0;
    if (w_count_next != '0) begin
      if (w_do_write && (r_wptr == w_rptr_next)) w_head_next = w_new;
      else                                       w_head_next = r_mem[w_rptr_next];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_write) r_mem[r_wptr] <= w_new;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_ok) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycle    <= '0;
      r_head     <= '0;
    end else begin
      r_rptr  <= w_rptr_next;
      r_wptr  <= w_wptr_next;
      r_count <= w_count_next;
      r_head  <= w_head_next;
      if (w_drop || w_overwrite) r_overflow <= 1'b1;
      if (w_sample && (r_cycle != '1)) r_cycle <= r_cycle + CNT_W'(1);
    end
  end

  assign rd_valid_o = (r_count != '0);
  assign rd_cycle_o = r_head.cycle;
  assign rd_pc_o    = r_head.pc;
  assign rd_instr_o = r_head.instr;
  assign rd_flags_o = r_head.flags;
  assign rd_raddr_o = r_head.raddr;
  assign rd_rdata_o = r_head.rdata;
  assign rd_maddr_o = r_head.maddr;
  assign rd_mdata_o = r_head.mdata;
  assign count_o    = r_count;
  assign state_o    = r_state;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: three instances (capture-all/drop, filtered, capture-all/wrap).
module tb_cpu_trace_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop;
  logic [31:0] pc, instr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  logic        rdy   [3];
  logic        valid [3];
  logic [15:0] cyc   [3];
  logic [31:0] rpc   [3];
  logic [31:0] rins  [3];
  logic [1:0]  flg   [3];
  logic [4:0]  rra   [3];
  logic [31:0] rrd   [3];
  logic [11:0] rma   [3];
  logic [31:0] rmd   [3];
  logic [4:0]  cnt   [3];
  logic [1:0]  st    [3];
  logic        ovf   [3];

  int checks = 0;
  int errors = 0;
  int exp_stamp;

  // Instance 0: CAPTURE_ALL=1 WRAP=0; 1: CAPTURE_ALL=0 WRAP=0; 2: CAPTURE_ALL=1 WRAP=1
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    cpu_trace_buffer #(
      .CAPTURE_ALL((gi == 1) ? 0 : 1),
      .WRAP       ((gi == 2) ? 1 : 0)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .stop_i     (stop),
      .pc_i       (pc),
      .instr_i    (instr),
      .rf_we_i    (rf_we),
      .rf_waddr_i (rf_waddr),
      .rf_wdata_i (rf_wdata),
      .mem_we_i   (mem_we),
      .mem_addr_i (mem_addr),
      .mem_wdata_i(mem_wdata),
      .rd_valid_o (valid[gi]),
      .rd_ready_i (rdy[gi]),
      .rd_cycle_o (cyc[gi]),
      .rd_pc_o    (rpc[gi]),
      .rd_instr_o (rins[gi]),
      .rd_flags_o (flg[gi]),
      .rd_raddr_o (rra[gi]),
      .rd_rdata_o (rrd[gi]),
      .rd_maddr_o (rma[gi]),
      .rd_mdata_o (rmd[gi]),
      .count_o    (cnt[gi]),
      .state_o    (st[gi]),
      .overflow_o (ovf[gi])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_wr();
    rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
    mem_we = 1'b0; mem_addr = 12'd0; mem_wdata = 32'd0;
  endtask

  task automatic pop(input int idx);
    $display("rd dut%0d cycle %0d pc %08h flags %0d", idx, cyc[idx], rpc[idx], flg[idx]);
    rdy[idx] = 1'b1;
    tick();
    rdy[idx] = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pc = '0; instr = '0;
    clr_wr();
    for (int i = 0; i < 3; i++) rdy[i] = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_state", st[0], 0);
    chk("rst_count", cnt[0], 0);
    chk("rst_valid", valid[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_pc", rpc[0], 0);
    chk("rst_cycle", cyc[0], 0);

    // Capture-all, no writes, five cycles
    pulse_start();
    chk("t1_state_run", st[0], 1);
    for (int i = 0; i < 5; i++) begin
      pc = 32'h100 + 32'(4 * i);
      instr = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 0) begin
        chk("t1_first_valid", valid[0], 1);
        chk("t1_first_cycle", cyc[0], 0);
        chk("t1_first_pc", rpc[0], 32'h100);
      end
    end
    chk("t1_count5", cnt[0], 5);
    pc = 32'hDEAD;
    pulse_stop();
    chk("t1_state_done", st[0], 2);
    chk("t1_stop_not_sampled", cnt[0], 5);
    chk("t1_filtered_empty", cnt[1], 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_cycle", cyc[0], 64'(i));
      chk("t1_pc", rpc[0], 64'(32'h100 + 32'(4 * i)));
      chk("t1_instr", rins[0], 64'(32'hA000_0000 + 32'(i)));
      chk("t1_flags", flg[0], 0);
      pop(0);
    end
    chk("t1_drained", valid[0], 0);

    // Filtered capture: R3=7 @2, mem[100]=9 @4, R0=5 @5
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      clr_wr();
      pc = 32'h200 + 32'(4 * i);
      if (i == 2) begin
        rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'd7;
        mem_addr = 12'd55; mem_wdata = 32'h77;
      end
      if (i == 4) begin
        mem_we = 1'b1; mem_addr = 12'd100; mem_wdata = 32'd9;
        rf_waddr = 5'd9; rf_wdata = 32'h1234;
      end
      if (i == 5) begin
        rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'd5;
      end
      tick();
    end
    clr_wr();
    pulse_stop();
    chk("t2_count", cnt[1], 2);
    chk("t2_e0_cycle", cyc[1], 2);
    chk("t2_e0_flags", flg[1], 1);
    chk("t2_e0_raddr", rra[1], 3);
    chk("t2_e0_rdata", rrd[1], 7);
    chk("t2_e0_maddr", rma[1], 0);
    chk("t2_e0_mdata", rmd[1], 0);
    chk("t2_e0_pc", rpc[1], 32'h208);
    pop(1);
    chk("t2_e1_cycle", cyc[1], 4);
    chk("t2_e1_flags", flg[1], 2);
    chk("t2_e1_maddr", rma[1], 100);
    chk("t2_e1_mdata", rmd[1], 9);
    chk("t2_e1_raddr", rra[1], 0);
    chk("t2_e1_rdata", rrd[1], 0);
    pop(1);
    chk("t2_drained", valid[1], 0);

    // Cycle budget with continuous readout
    rdy[0] = 1'b1;
    pulse_start();
    exp_stamp = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (valid[0]) begin
        chk("t3_stamp", cyc[0], 64'(exp_stamp));
        exp_stamp++;
      end
    end
    rdy[0] = 1'b0;
    chk("t3_entries", 64'(exp_stamp), 154);
    chk("t3_state_done", st[0], 2);
    chk("t3_ovf", ovf[0], 0);
    chk("t3_count", cnt[0], 0);

    // 20 cycles into a 16-entry buffer, no readout
    pulse_start();
    for (int k = 0; k < 20; k++) tick();
    pulse_stop();
    chk("t4_drop_count", cnt[0], 16);
    chk("t4_drop_head", cyc[0], 0);
    chk("t4_drop_ovf", ovf[0], 1);
    chk("t4_wrap_count", cnt[2], 16);
    chk("t4_wrap_head", cyc[2], 4);
    chk("t4_wrap_ovf", ovf[2], 1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_wrap_stamp", cyc[2], 64'(4 + i));
      pop(2);
    end
    chk("t4_wrap_drained", valid[2], 0);

    // Fill, ignore start in RUN, then push+pop while full, then reset mid-run
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      start = (k == 9);
      tick();
    end
    start = 1'b0;
    chk("t5_full", cnt[0], 16);
    chk("t5_ovf0", ovf[0], 0);
    chk("t5_still_run", st[0], 1);
    rdy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_pp_count", cnt[0], 16);
      chk("t5_pp_ovf", ovf[0], 0);
    end
    rdy[0] = 1'b0;
    chk("t5_head", cyc[0], 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_count", cnt[0], 0);
    chk("t5_rst_state", st[0], 0);
    chk("t5_rst_valid", valid[0], 0);
    chk("t5_rst_cycle", cyc[0], 0);
    pulse_stop();
    chk("t5_stop_idle", st[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
